box_drawer: RTL
===============

# box_drawer

Draws filled solid-colour rectangles on the VGA pixel bus. Sits directly downstream of the box reset sequencer and the player box-update logic: it accepts top-left box coordinates plus a colour through a valid/ready handshake, queues them in a small FIFO, and emits one pixel per cycle (plot, x, y, colour) to the VGA adapter. This lets upstream stages issue a burst of box coordinates without waiting for each box to finish rendering.

## Interface
- BOX_W, 4, box width in pixels (1..16)
- BOX_H, 4, box height in pixels (1..16)
- FIFO_DEPTH, 4, request queue depth (power of two, ≥2)

- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  upstream presents a box request
- req_x  in  8  box top-left x
- req_y  in  7  box top-left y
- req_colour  in  3  box fill colour
- req_ready  out  1  queue can accept; request taken when req_valid && req_ready
- plot  out  1  write enable to VGA adapter
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- box_done  out  1  one-cycle pulse after a box's final pixel
- busy  out  1  state != IDLE or FIFO non-empty

## Operation
- FIFO: stores {x,y,colour}; count 0..FIFO_DEPTH. req_ready = (count < FIFO_DEPTH) && !reset; depends on registered count only, never on a same-cycle pop.
- Push and pop in the same cycle leave count unchanged. No bypass: a request pushed into an empty FIFO is popped no earlier than the following cycle.
- States: IDLE, DRAW, DONE.
  - IDLE: if FIFO non-empty, pop head, latch base_x/base_y/colour, clear col and row, go to DRAW. Otherwise stay.
  - DRAW: plot=1, vga_x = base_x + col (mod 256), vga_y = base_y + row (mod 128), vga_colour = latched colour. Scan is row-major with col fastest. At col=BOX_W-1 and row=BOX_H-1, go to DONE.
  - DONE: box_done=1, plot=0. If FIFO non-empty, pop and go to DRAW. Otherwise go to IDLE.
- Coordinate addition truncates to port width, so a box wraps around the screen edge. Colour 000 is drawn like any other colour (used for erase).
- Outputs come from registers and state only; there is no combinational path from req_* to plot/vga_*.
- Reset (any cycle, including mid-box): at the next edge the FIFO is emptied, state goes to IDLE, and counters clear. The partially drawn box is abandoned and gets no box_done.
- Reset values: plot=0, vga_x=0, vga_y=0, vga_colour=0, box_done=0, busy=0. req_ready=0 while reset is high and 1 on the first cycle after release.

## Timing
- Request accepted in cycle A, FIFO idle and empty: pop in A+1, first plot in A+2, last plot in A+1+BOX_W·BOX_H, box_done in A+2+BOX_W·BOX_H, IDLE or next box after that.
- Back-to-back boxes: exactly one non-plot cycle (the DONE cycle) between consecutive boxes. Throughput is one box per BOX_W·BOX_H+1 cycles.
- vga_x/vga_y/vga_colour are don't-care when plot=0 but must hold their last values (no toggling).
- busy falls in the cycle after the final DONE when the FIFO is empty.

## Test plan
- Single box: accept (43,7,111) at cycle 0 with defaults → 16 plots in cycles 2–17 at x 43..46 × y 7..10, row-major, colour 111; box_done only at cycle 18; busy low at cycle 19.
- Wrap: box at (254,126), colour 010 → x sequence 254,255,0,1; rows 126,127,0,1; 16 plots, no X values on outputs.
- Backpressure: hold req_valid high with distinct coordinates from cycle 0 → five requests accepted in cycles 0–4; req_ready low from cycle 5 until the first box_done pop. Boxes are drawn in acceptance order with no loss or duplication.
- Back-to-back: two queued boxes → last plot of box 1 in cycle 17, box_done in 18, first plot of box 2 in 19.
- Reset mid-box: assert reset for one cycle at the 7th plot of a box with 2 more queued → plot=0 on the next edge. No box_done follows, and no further plots occur until a new request arrives. req_ready=1 after release.
- Upstream burst: feed the 16-coordinate reset sequence, colour 111, honouring req_ready → 256 plots total, 16 box_done pulses, all pixels white and matching each requested base coordinate.

Source files
------------

// File: rtl/box_drawer.sv
// Filled-rectangle renderer: queues box requests in a small FIFO and scans each box
// row-major, emitting one registered pixel per cycle to the VGA adapter.
module box_drawer #(
   parameter int unsigned BOX_W      = 4,
   parameter int unsigned BOX_H      = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [7:0] req_x,
   input  logic [6:0] req_y,
   input  logic [2:0] req_colour,
   output logic       req_ready,
   output logic       plot,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       box_done,
   output logic       busy
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

   state_e          state_q;
   logic [17:0]     mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic [7:0]      base_x_q;
   logic [6:0]      base_y_q;
   logic [3:0]      col_q, row_q;

   logic       push, pop;
   logic [7:0] head_x;
   logic [6:0] head_y;
   logic [2:0] head_c;
   logic       last_col, last_row;
   logic [3:0] col_nxt, row_nxt;

   // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
   assign req_ready = (count_q < CntW'(FIFO_DEPTH)) && !reset;
   assign push      = req_valid && req_ready;
   assign pop       = (state_q != StDraw) && (count_q != '0);
   assign {head_x, head_y, head_c} = mem_q[rd_ptr_q];
   assign busy      = (state_q != StIdle) || (count_q != '0);

   assign last_col = (col_q == 4'(BOX_W - 1));
   assign last_row = (row_q == 4'(BOX_H - 1));
   assign col_nxt  = last_col ? 4'd0 : col_q + 4'd1;
   assign row_nxt  = last_col ? row_q + 4'd1 : row_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {req_x, req_y, req_colour};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         base_x_q   <= '0;
         base_y_q   <= '0;
         col_q      <= '0;
         row_q      <= '0;
         plot       <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         box_done   <= 1'b0;
      end else begin
         box_done <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (pop) begin
                  // The first pixel is the head entry itself, presented on the next cycle.
                  state_q    <= StDraw;
                  base_x_q   <= head_x;
                  base_y_q   <= head_y;
                  col_q      <= '0;
                  row_q      <= '0;
                  plot       <= 1'b1;
                  vga_x      <= head_x;
                  vga_y      <= head_y;
                  vga_colour <= head_c;
               end else begin
                  state_q <= StIdle;
                  plot    <= 1'b0;
               end
            end
            StDraw: begin
               if (last_col && last_row) begin
                  state_q  <= StDone;
                  plot     <= 1'b0;
                  box_done <= 1'b1;
               end else begin
                  col_q <= col_nxt;
                  row_q <= row_nxt;
                  plot  <= 1'b1;
                  vga_x <= base_x_q + 8'(col_nxt);
                  vga_y <= base_y_q + 7'(row_nxt);
               end
            end
            default: begin
               state_q <= StIdle;
               plot    <= 1'b0;
            end
         endcase
      end
   end

endmodule
